// File: rtl/t77_pkg.sv
// Shared types and helpers for the T77 cassette-image player.
// A record word packs the output level in bit 7 and a 15-bit length in the remaining bits.
package t77_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSpinup,
        StPlay,
        StPause,
        StEot
    } player_state_e;

    // 9 us tick at a 32 MHz system clock: 288 cycles per tick.
    localparam int unsigned T77_TICK_DIV_9US_32MHZ = 287;

    localparam int unsigned T77_LEN_W = 15;

    function automatic logic t77_level(input logic [15:0] word);
        return word[7];
    endfunction

    function automatic logic [T77_LEN_W-1:0] t77_len(input logic [15:0] word);
        return {word[6:0], word[15:8]};
    endfunction

endpackage

// File: rtl/t77_fifo.sv
// Small synchronous prefetch FIFO. The extra pointer bit tells full from empty.
// Flush wins over a push in the same cycle; a push is refused while full.
module t77_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/t77_player.sv
// T77 cassette-image player: prefetches pulse records from SDRAM and replays them on sout,
// one time unit per divider tick, with motor spin-up, pause/resume, rewind and end-of-tape.
module t77_player
    import t77_pkg::*;
#(
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned START_ADDR  = 16,
    parameter int unsigned TICK_DIV    = T77_TICK_DIV_9US_32MHZ,
    parameter int unsigned SPINUP_CLKS = 16384,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic              CLKSYS,
    input  logic              RSTn,
    input  logic              motor,
    input  logic              rewind,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_rd,
    input  logic [15:0]       sdram_data,
    input  logic              sdram_stb,
    output logic              sout,
    output logic              playing,
    output logic              eot,
    output logic              underrun
);

    localparam int unsigned DIV_W  = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam int unsigned SPIN_W = (SPINUP_CLKS > 1) ? $clog2(SPINUP_CLKS + 1) : 1;

    localparam logic [ADDR_W-1:0]    START     = ADDR_W'(START_ADDR);
    localparam logic [DIV_W-1:0]     DIV_MAX   = DIV_W'(TICK_DIV);
    localparam logic [SPIN_W-1:0]    SPIN_LAST = SPIN_W'(SPINUP_CLKS - 1);
    localparam logic [T77_LEN_W-1:0] LEN_ONE   = T77_LEN_W'(1);

    player_state_e        state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [SPIN_W-1:0]    spin_q, spin_d;
    logic [T77_LEN_W-1:0] rem_q, rem_d;
    logic                 sout_q, sout_d;
    logic                 underrun_q, underrun_d;
    logic                 motor_q;
    logic [ADDR_W-1:0]    ptr_q, ptr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 req_q, req_d;
    logic                 discard_q, discard_d;

    logic                 motor_rise;
    logic                 motor_fall;
    logic                 tick;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [15:0]          fifo_rdata;
    logic [T77_LEN_W-1:0] head_len;

    assign motor_rise = motor & ~motor_q;
    assign motor_fall = ~motor & motor_q;
    assign tick       = (div_q == DIV_MAX);
    assign head_len   = t77_len(fifo_rdata);

    t77_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (CLKSYS),
        .rst_n (RSTn),
        .flush (rewind),
        .push  (fifo_push),
        .wdata (sdram_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Fetcher: one outstanding read at a time; a read in flight across a rewind is
    // completed on the bus but its data is dropped.
    always_comb begin
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        req_d     = req_q;
        discard_d = discard_q;
        fifo_push = 1'b0;
        if (req_q) begin
            if (sdram_stb) begin
                req_d     = 1'b0;
                discard_d = 1'b0;
                if (!discard_q && !rewind) begin
                    fifo_push = 1'b1;
                    ptr_d     = ptr_q + ADDR_W'(2);
                end
            end else if (rewind) begin
                discard_d = 1'b1;
            end
        end else if (!rewind && !fifo_full && (ptr_q < end_addr)) begin
            req_d  = 1'b1;
            addr_d = ptr_q;
        end
        if (rewind) begin
            ptr_d = START;
        end
    end

    // Player state machine and tick divider.
    always_comb begin
        state_d    = state_q;
        spin_d     = spin_q;
        rem_d      = rem_q;
        sout_d     = sout_q;
        underrun_d = underrun_q;
        fifo_pop   = 1'b0;
        div_d      = tick ? '0 : div_q + DIV_W'(1);

        unique case (state_q)
            StIdle: begin
                if (motor_rise) begin
                    state_d = StSpinup;
                    spin_d  = '0;
                end
            end
            StSpinup: begin
                if (motor_fall) begin
                    state_d = StIdle;
                    div_d   = '0;
                end else if (spin_q == SPIN_LAST) begin
                    state_d = StPlay;
                    div_d   = '0;
                end else begin
                    spin_d = spin_q + SPIN_W'(1);
                end
            end
            StPlay: begin
                if (motor_fall) begin
                    state_d = StPause;
                end else if (tick) begin
                    if (rem_q > LEN_ONE) begin
                        rem_d = rem_q - LEN_ONE;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        sout_d   = t77_level(fifo_rdata);
                        rem_d    = (head_len == '0) ? LEN_ONE : head_len;
                    end else if ((ptr_q >= end_addr) && !req_q) begin
                        state_d = StEot;
                        sout_d  = 1'b0;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            StPause: begin
                if (motor_rise) begin
                    state_d = StSpinup;
                    spin_d  = '0;
                end
            end
            StEot: begin
                sout_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (rewind) begin
            fifo_pop   = 1'b0;
            rem_d      = '0;
            sout_d     = 1'b0;
            underrun_d = 1'b0;
            spin_d     = '0;
            state_d    = motor ? StSpinup : StIdle;
        end
    end

    always_ff @(posedge CLKSYS or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= StIdle;
            div_q      <= '0;
            spin_q     <= '0;
            rem_q      <= '0;
            sout_q     <= 1'b0;
            underrun_q <= 1'b0;
            motor_q    <= 1'b0;
            ptr_q      <= START;
            addr_q     <= START;
            req_q      <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            spin_q     <= spin_d;
            rem_q      <= rem_d;
            sout_q     <= sout_d;
            underrun_q <= underrun_d;
            motor_q    <= motor;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            discard_q  <= discard_d;
        end
    end

    assign sdram_addr = addr_q;
    assign sdram_rd   = req_q;
    assign sout       = sout_q;
    assign playing    = (state_q == StPlay);
    assign eot        = (state_q == StEot);
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_t77_player.sv
// Directed bench for t77_player with a 4-cycle tick and 8-cycle spin-up; an SDRAM responder
// serves an image array with a configurable strobe delay and a monitor logs sout run lengths.
module tb_t77_player;

    localparam int unsigned AW = 25;
    localparam int unsigned SA = 16;
    localparam int unsigned TD = 3;
    localparam int unsigned SC = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          motor = 1'b0;
    logic          rewind = 1'b0;
    logic [AW-1:0] end_addr = AW'(SA);
    logic [AW-1:0] sdram_addr;
    logic          sdram_rd;
    logic [15:0]   sdram_data;
    logic          sdram_stb;
    logic          sout;
    logic          playing;
    logic          eot;
    logic          underrun;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0]   mem [16];
    int            stb_delay = 0;
    bit            resp_busy = 1'b0;
    int            n_reads = 0;
    logic [AW-1:0] read_addr [128];

    logic          seg_lvl [128];
    int            seg_len [128];
    int            seg_n = 0;

    always #5 clk = ~clk;

    t77_player #(
        .ADDR_W      (AW),
        .START_ADDR  (SA),
        .TICK_DIV    (TD),
        .SPINUP_CLKS (SC),
        .FIFO_DEPTH  (4)
    ) dut (
        .CLKSYS     (clk),
        .RSTn       (rst_n),
        .motor      (motor),
        .rewind     (rewind),
        .end_addr   (end_addr),
        .sdram_addr (sdram_addr),
        .sdram_rd   (sdram_rd),
        .sdram_data (sdram_data),
        .sdram_stb  (sdram_stb),
        .sout       (sout),
        .playing    (playing),
        .eot        (eot),
        .underrun   (underrun)
    );

    // SDRAM responder: strobe arrives stb_delay+1 edges after the request is seen.
    initial begin
        logic [AW-1:0] a;
        logic [AW-1:0] off;
        sdram_stb  = 1'b0;
        sdram_data = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (sdram_rd === 1'b1) begin
                resp_busy = 1'b1;
                a = sdram_addr;
                if (n_reads < 128) read_addr[n_reads] = a;
                n_reads++;
                repeat (stb_delay) begin
                    @(posedge clk);
                    #1;
                end
                off = (a - AW'(SA)) >> 1;
                sdram_data = (off < 16) ? mem[off[3:0]] : 16'hFFFF;
                sdram_stb  = 1'b1;
                @(posedge clk);
                #1;
                sdram_stb = 1'b0;
                resp_busy = 1'b0;
            end
        end
    end

    // Run-length log of sout in clock cycles.
    initial begin
        logic last;
        int   run;
        last = 1'b0;
        run  = 0;
        forever begin
            @(negedge clk);
            if (sout !== last) begin
                if (seg_n < 128) begin
                    seg_lvl[seg_n] = last;
                    seg_len[seg_n] = run;
                end
                seg_n++;
                last = sout;
                run  = 1;
            end else begin
                run++;
            end
        end
    end

    task automatic do_reset();
        for (int k = 0; k < 100 && resp_busy; k++) @(posedge clk);
        motor    = 1'b0;
        rewind   = 1'b0;
        end_addr = AW'(SA);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_eot(input int budget);
        for (int k = 0; k < budget && eot !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (sout !== 1'b0) begin n_fail++; $display("FAIL reset_sout: got %b want 0", sout); end
        n_cmp++; if (sdram_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b want 0", sdram_rd); end
        n_cmp++; if (sdram_addr !== AW'(SA)) begin n_fail++; $display("FAIL reset_addr: got %0d want %0d", sdram_addr, SA); end
        n_cmp++; if (playing !== 1'b0) begin n_fail++; $display("FAIL reset_playing: got %b want 0", playing); end
        n_cmp++; if (eot !== 1'b0) begin n_fail++; $display("FAIL reset_eot: got %b want 0", eot); end
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_basic();
        int rb;
        int sb;
        do_reset();
        mem[0] = 16'h0380;
        mem[1] = 16'h0200;
        mem[2] = 16'h0180;
        stb_delay = 0;
        rb = n_reads;
        sb = seg_n;
        end_addr = AW'(SA + 6);
        motor = 1'b1;
        wait_eot(400);
        n_cmp++; if (eot !== 1'b1) begin n_fail++; $display("FAIL basic_eot: got %b want 1", eot); end
        n_cmp++; if (sout !== 1'b0) begin n_fail++; $display("FAIL basic_sout_eot: got %b want 0", sout); end
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL basic_underrun: got %b want 0", underrun); end
        n_cmp++; if (n_reads - rb !== 3) begin n_fail++; $display("FAIL basic_nreads: got %0d want 3", n_reads - rb); end
        n_cmp++; if (read_addr[rb] !== AW'(16)) begin n_fail++; $display("FAIL basic_addr0: got %0d want 16", read_addr[rb]); end
        n_cmp++; if (read_addr[rb+1] !== AW'(18)) begin n_fail++; $display("FAIL basic_addr1: got %0d want 18", read_addr[rb+1]); end
        n_cmp++; if (read_addr[rb+2] !== AW'(20)) begin n_fail++; $display("FAIL basic_addr2: got %0d want 20", read_addr[rb+2]); end
        n_cmp++; if (seg_lvl[sb+1] !== 1'b1 || seg_len[sb+1] !== 12) begin n_fail++; $display("FAIL basic_rec0: got lvl %b len %0d want lvl 1 len 12", seg_lvl[sb+1], seg_len[sb+1]); end
        n_cmp++; if (seg_lvl[sb+2] !== 1'b0 || seg_len[sb+2] !== 8) begin n_fail++; $display("FAIL basic_rec1: got lvl %b len %0d want lvl 0 len 8", seg_lvl[sb+2], seg_len[sb+2]); end
        n_cmp++; if (seg_lvl[sb+3] !== 1'b1 || seg_len[sb+3] !== 4) begin n_fail++; $display("FAIL basic_rec2: got lvl %b len %0d want lvl 1 len 4", seg_lvl[sb+3], seg_len[sb+3]); end
    endtask

    task automatic test_len0();
        int sb;
        do_reset();
        mem[0] = 16'h0080;
        stb_delay = 0;
        sb = seg_n;
        end_addr = AW'(SA + 2);
        motor = 1'b1;
        wait_eot(400);
        n_cmp++; if (eot !== 1'b1) begin n_fail++; $display("FAIL len0_eot: got %b want 1", eot); end
        n_cmp++; if (seg_lvl[sb+1] !== 1'b1 || seg_len[sb+1] !== 4) begin n_fail++; $display("FAIL len0_rec: got lvl %b len %0d want lvl 1 len 4", seg_lvl[sb+1], seg_len[sb+1]); end
    endtask

    task automatic test_pause();
        int c;
        do_reset();
        mem[0] = 16'h0A80;
        mem[1] = 16'h0100;
        stb_delay = 0;
        end_addr = AW'(SA + 4);
        motor = 1'b1;
        for (int k = 0; k < 200 && sout !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        repeat (5) @(posedge clk);
        #1 motor = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (sout !== 1'b1) begin n_fail++; $display("FAIL pause_sout_held: got %b want 1", sout); end
        n_cmp++; if (playing !== 1'b0) begin n_fail++; $display("FAIL pause_playing: got %b want 0", playing); end
        motor = 1'b1;
        for (int k = 0; k < 100 && playing !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        c = 0;
        for (int k = 0; k < 200 && sout !== 1'b0; k++) begin
            @(posedge clk);
            #1;
            c++;
        end
        n_cmp++; if (c !== 36) begin n_fail++; $display("FAIL pause_resume_cycles: got %0d want 36", c); end
        wait_eot(200);
        n_cmp++; if (eot !== 1'b1) begin n_fail++; $display("FAIL pause_eot: got %b want 1", eot); end
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL pause_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_underrun();
        int sb;
        do_reset();
        mem[0] = 16'h0280;
        mem[1] = 16'h0300;
        mem[2] = 16'h0180;
        stb_delay = 5 * (TD + 1);
        sb = seg_n;
        end_addr = AW'(SA + 6);
        motor = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_flag: got %b want 1", underrun); end
        n_cmp++; if (sout !== 1'b0) begin n_fail++; $display("FAIL underrun_sout_hold: got %b want 0", sout); end
        wait_eot(800);
        n_cmp++; if (eot !== 1'b1) begin n_fail++; $display("FAIL underrun_eot: got %b want 1", eot); end
        n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b want 1", underrun); end
        n_cmp++; if (seg_lvl[sb+1] !== 1'b1 || seg_len[sb+1] !== 20) begin n_fail++; $display("FAIL underrun_rec0: got lvl %b len %0d want lvl 1 len 20", seg_lvl[sb+1], seg_len[sb+1]); end
        n_cmp++; if (seg_lvl[sb+2] !== 1'b0 || seg_len[sb+2] !== 24) begin n_fail++; $display("FAIL underrun_rec1: got lvl %b len %0d want lvl 0 len 24", seg_lvl[sb+2], seg_len[sb+2]); end
        n_cmp++; if (seg_lvl[sb+3] !== 1'b1 || seg_len[sb+3] !== 4) begin n_fail++; $display("FAIL underrun_rec2: got lvl %b len %0d want lvl 1 len 4", seg_lvl[sb+3], seg_len[sb+3]); end
    endtask

    // Continues from the end-of-tape state left by test_underrun (eot=1, underrun=1).
    task automatic test_rewind();
        int rb;
        int sb;
        motor = 1'b0;
        stb_delay = 10;
        mem[0] = 16'h0380;
        mem[1] = 16'h0200;
        mem[3] = 16'h7F80;
        rb = n_reads;
        end_addr = AW'(SA + 8);
        for (int k = 0; k < 50 && sdram_rd !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        end_addr = AW'(SA + 4);
        rewind = 1'b1;
        stb_delay = 0;
        @(posedge clk);
        #1 rewind = 1'b0;
        n_cmp++; if (eot !== 1'b0) begin n_fail++; $display("FAIL rewind_eot_clr: got %b want 0", eot); end
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL rewind_underrun_clr: got %b want 0", underrun); end
        n_cmp++; if (sdram_rd !== 1'b1) begin n_fail++; $display("FAIL rewind_rd_held: got %b want 1", sdram_rd); end
        n_cmp++; if (sdram_addr !== AW'(SA + 6)) begin n_fail++; $display("FAIL rewind_addr_held: got %0d want %0d", sdram_addr, SA + 6); end
        repeat (30) @(posedge clk);
        #1;
        n_cmp++; if (read_addr[rb] !== AW'(SA + 6)) begin n_fail++; $display("FAIL rewind_stale_addr: got %0d want %0d", read_addr[rb], SA + 6); end
        n_cmp++; if (read_addr[rb+1] !== AW'(SA)) begin n_fail++; $display("FAIL rewind_first_new: got %0d want %0d", read_addr[rb+1], SA); end
        sb = seg_n;
        motor = 1'b1;
        wait_eot(400);
        n_cmp++; if (eot !== 1'b1) begin n_fail++; $display("FAIL rewind_eot: got %b want 1", eot); end
        n_cmp++; if (n_reads - rb !== 3) begin n_fail++; $display("FAIL rewind_nreads: got %0d want 3", n_reads - rb); end
        n_cmp++; if (seg_lvl[sb+1] !== 1'b1 || seg_len[sb+1] !== 12) begin n_fail++; $display("FAIL rewind_rec0: got lvl %b len %0d want lvl 1 len 12", seg_lvl[sb+1], seg_len[sb+1]); end
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL rewind_underrun_end: got %b want 0", underrun); end
    endtask

    task automatic test_reset_mid_play();
        int rd_seen;
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = 16'h0A80;
        stb_delay = 0;
        end_addr = AW'(SA + 20);
        motor = 1'b1;
        for (int k = 0; k < 200 && sout !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (sout !== 1'b0) begin n_fail++; $display("FAIL rstmid_sout: got %b want 0", sout); end
        n_cmp++; if (playing !== 1'b0) begin n_fail++; $display("FAIL rstmid_playing: got %b want 0", playing); end
        n_cmp++; if (sdram_rd !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd: got %b want 0", sdram_rd); end
        n_cmp++; if (sdram_addr !== AW'(SA)) begin n_fail++; $display("FAIL rstmid_addr: got %0d want %0d", sdram_addr, SA); end
        n_cmp++; if (eot !== 1'b0 || underrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got eot %b underrun %b want 0 0", eot, underrun); end
        rd_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (sdram_rd !== 1'b0) rd_seen++;
        end
        n_cmp++; if (rd_seen !== 0) begin n_fail++; $display("FAIL rstmid_no_req: got %0d request cycles want 0", rd_seen); end
        motor = 1'b0;
        end_addr = AW'(SA);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (sdram_rd !== 1'b0 || playing !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got rd %b playing %b want 0 0", sdram_rd, playing); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        test_reset();
        test_basic();
        test_len0();
        test_pause();
        test_underrun();
        test_rewind();
        test_reset_mid_play();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
